mlp_sequencer: RTL and testbench
================================

MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 104, meaning input-layer fan-in (taps per hidden neuron).
REQ-002 SHALL have parameter N_HID, default 60, meaning hidden-neuron count and fan-in per output neuron.
REQ-003 SHALL have parameter N_OUT, default 20, meaning output-neuron count.
REQ-004 SHALL have parameter ACT_LAT, default 10, meaning activation-unit latency in cycles.
REQ-005 SHALL have parameter CHK_LAT, default 10, meaning checker latency in cycles.
REQ-006 SHALL have parameter IDX_W, default 8, meaning width of index outputs.
REQ-007 SHALL have port clk, input, 1, meaning clock; all logic on rising edge only.
REQ-008 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-009 SHALL have port start, input, 1, meaning run request, sampled in IDLE only.
REQ-010 SHALL have port abort, input, 1, meaning synchronous run cancel.
REQ-011 SHALL have port busy, output, 1, meaning a run is in progress (MAC..CHECK).
REQ-012 SHALL have port done, output, 1, meaning one-cycle run-complete pulse.
REQ-013 SHALL have port layer, output, 1, meaning 0 = hidden, 1 = output layer.
REQ-014 SHALL have port neuron_idx, output, IDX_W, meaning current neuron in layer.
REQ-015 SHALL have port tap_idx, output, IDX_W, meaning current MAC input/weight index.
REQ-016 SHALL have port mac_init, output, 1, meaning clear accumulator; first MAC cycle of each neuron.
REQ-017 SHALL have port mac_en, output, 1, meaning accumulate this cycle.
REQ-018 SHALL have port act_en, output, 1, meaning activation unit enable.
REQ-019 SHALL have port wr_en, output, 1, meaning latch activation result into slot neuron_idx of the current layer.
REQ-020 SHALL have port chk_en, output, 1, meaning argmax checker enable.

Function
REQ-021 SHALL implement FSM states IDLE, MAC, ACT, WRITE, CHECK, DONE; all outputs SHALL be registered, decoded from state/counters, with no combinational path from inputs.
REQ-022 IDLE: start=1 and abort=0 -> MAC at next edge with layer=0, neuron_idx=0, tap_idx=0; start SHALL be ignored in all other states.
REQ-023 MAC: lasts FANIN cycles (N_IN if layer=0, else N_HID); tap_idx counts 0..FANIN-1; mac_en=1 every cycle; mac_init=1 only when tap_idx=0; then -> ACT.
REQ-024 ACT: act_en=1 for exactly ACT_LAT cycles, tap_idx held 0; then -> WRITE.
REQ-025 WRITE: wr_en=1 for exactly one cycle with neuron_idx and layer of the finished neuron.
REQ-026 After WRITE: if neuron_idx < LAST (N_HID-1 or N_OUT-1) then neuron_idx+1, -> MAC; else if layer=0 then layer=1, neuron_idx=0, -> MAC; else -> CHECK.
REQ-027 CHECK: chk_en=1 for exactly CHK_LAT cycles; then -> DONE.
REQ-028 DONE: done=1, busy=0 for one cycle; -> IDLE unconditionally.
REQ-029 busy SHALL be 1 in MAC, ACT, WRITE, CHECK; 0 in IDLE, DONE.
REQ-030 Start-to-done latency SHALL be N_HID*(N_IN+ACT_LAT+1) + N_OUT*(N_HID+ACT_LAT+1) + CHK_LAT + 1 cycles (8331 at defaults), done in that cycle after the start-sampling edge.
REQ-031 abort=1 in any state SHALL force IDLE at next edge, clear all counters and outputs, suppress done; abort beats start in the same cycle.
REQ-032 Counters SHALL never wrap; terminal compares use FANIN-1, ACT_LAT-1, CHK_LAT-1 exactly.
REQ-033 Elaboration SHALL fail if any of N_IN, N_HID, N_OUT, ACT_LAT, CHK_LAT < 1 or max(N_IN, N_HID, N_OUT) > 2^IDX_W.
REQ-034 In IDLE and DONE, layer, neuron_idx, tap_idx, mac_init, mac_en, act_en, wr_en, chk_en SHALL be 0.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE and all outputs and counters to 0, independent of clk.
REQ-036 Reset deassertion mid-run SHALL NOT resume; a new start is required.

Verification
REQ-037 Defaults, start pulse -> done exactly 8331 cycles later; 80 wr_en pulses (60 layer=0, 20 layer=1); 80 mac_init pulses.
REQ-038 N_IN=3, N_HID=2, N_OUT=2, ACT_LAT=2, CHK_LAT=2 -> done at cycle 25; tap_idx sequence 0,1,2 then 0,1; mac_en high 10 cycles total.
REQ-039 abort during second output neuron -> IDLE next cycle, busy=0, no done; new start -> full 8331-cycle run.
REQ-040 start and abort both high in IDLE -> remains IDLE; start held high throughout a run -> exactly one run, next run starts the cycle after DONE.
REQ-041 rst_n asserted mid-ACT between clock edges -> all outputs 0 immediately; no activity after release until start.
REQ-042 N_IN=1, N_HID=1, N_OUT=1, ACT_LAT=1, CHK_LAT=1 -> mac_init and mac_en coincide each MAC; done at cycle 8.

Source files
------------

// File: rtl/mlp_sequencer.sv
// Control sequencer for a two-layer MLP datapath: walks every neuron through
// MAC, activation and write-back, then runs the argmax checker and pulses done.
module mlp_sequencer #(
  parameter int N_IN    = 104,
  parameter int N_HID   = 60,
  parameter int N_OUT   = 20,
  parameter int ACT_LAT = 10,
  parameter int CHK_LAT = 10,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             layer,
  output logic [IDX_W-1:0] neuron_idx,
  output logic [IDX_W-1:0] tap_idx,
  output logic             mac_init,
  output logic             mac_en,
  output logic             act_en,
  output logic             wr_en,
  output logic             chk_en,
  output logic [2:0]       state_dbg
);

  localparam int MAX_N   = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                          : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int LAT_MAX = (ACT_LAT > CHK_LAT) ? ACT_LAT : CHK_LAT;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  if (N_IN < 1 || N_HID < 1 || N_OUT < 1 || ACT_LAT < 1 || CHK_LAT < 1 ||
      longint'(MAX_N) > (longint'(1) << IDX_W)) begin : g_param_check
    $error("mlp_sequencer: illegal parameter combination");
  end

  localparam logic [IDX_W-1:0] IN_TAP_LAST  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] HID_TAP_LAST = IDX_W'(N_HID - 1);
  localparam logic [IDX_W-1:0] HID_LAST     = IDX_W'(N_HID - 1);
  localparam logic [IDX_W-1:0] OUT_LAST     = IDX_W'(N_OUT - 1);
  localparam logic [LAT_W-1:0] ACT_LAST     = LAT_W'(ACT_LAT - 1);
  localparam logic [LAT_W-1:0] CHK_LAST     = LAT_W'(CHK_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_ACT   = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             layer_q, layer_d;
  logic [IDX_W-1:0] neuron_q, neuron_d;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic             busy_nx, done_nx, layer_nx;
  logic [IDX_W-1:0] neuron_nx, tap_nx;
  logic             mac_init_nx, mac_en_nx, act_en_nx, wr_en_nx, chk_en_nx;

  logic [IDX_W-1:0] tap_last;
  logic [IDX_W-1:0] neuron_last;

  // Fan-in and neuron count both depend on which layer is being processed.
  assign tap_last    = layer_q ? HID_TAP_LAST : IN_TAP_LAST;
  assign neuron_last = layer_q ? OUT_LAST : HID_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      layer_q    <= 1'b0;
      neuron_q   <= '0;
      tap_q      <= '0;
      lat_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      layer      <= 1'b0;
      neuron_idx <= '0;
      tap_idx    <= '0;
      mac_init   <= 1'b0;
      mac_en     <= 1'b0;
      act_en     <= 1'b0;
      wr_en      <= 1'b0;
      chk_en     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      neuron_q   <= neuron_d;
      tap_q      <= tap_d;
      lat_q      <= lat_d;
      busy       <= busy_nx;
      done       <= done_nx;
      layer      <= layer_nx;
      neuron_idx <= neuron_nx;
      tap_idx    <= tap_nx;
      mac_init   <= mac_init_nx;
      mac_en     <= mac_en_nx;
      act_en     <= act_en_nx;
      wr_en      <= wr_en_nx;
      chk_en     <= chk_en_nx;
    end
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    tap_d    = tap_q;
    lat_d    = lat_q;
    if (abort) begin
      state_d  = S_IDLE;
      layer_d  = 1'b0;
      neuron_d = '0;
      tap_d    = '0;
      lat_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_MAC;
            layer_d  = 1'b0;
            neuron_d = '0;
            tap_d    = '0;
            lat_d    = '0;
          end
        end
        S_MAC: begin
          if (tap_q == tap_last) begin
            state_d = S_ACT;
            tap_d   = '0;
            lat_d   = '0;
          end else begin
            tap_d = tap_q + IDX_W'(1);
          end
        end
        S_ACT: begin
          if (lat_q == ACT_LAST) begin
            state_d = S_WRITE;
            lat_d   = '0;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        S_WRITE: begin
          // Layer/neuron stay valid through WRITE so the result lands in the right slot.
          if (neuron_q < neuron_last) begin
            state_d  = S_MAC;
            neuron_d = neuron_q + IDX_W'(1);
          end else if (!layer_q) begin
            state_d  = S_MAC;
            layer_d  = 1'b1;
            neuron_d = '0;
          end else begin
            state_d  = S_CHECK;
            layer_d  = 1'b0;
            neuron_d = '0;
            lat_d    = '0;
          end
        end
        S_CHECK: begin
          if (lat_q == CHK_LAST) begin
            state_d = S_DONE;
            lat_d   = '0;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d  = S_IDLE;
          layer_d  = 1'b0;
          neuron_d = '0;
          tap_d    = '0;
          lat_d    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered with
  // the state itself and never depend combinationally on start/abort.
  always_comb begin
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    layer_nx    = 1'b0;
    neuron_nx   = '0;
    tap_nx      = '0;
    mac_init_nx = 1'b0;
    mac_en_nx   = 1'b0;
    act_en_nx   = 1'b0;
    wr_en_nx    = 1'b0;
    chk_en_nx   = 1'b0;
    case (state_d)
      S_MAC: begin
        busy_nx     = 1'b1;
        layer_nx    = layer_d;
        neuron_nx   = neuron_d;
        tap_nx      = tap_d;
        mac_en_nx   = 1'b1;
        mac_init_nx = (tap_d == '0);
      end
      S_ACT: begin
        busy_nx   = 1'b1;
        layer_nx  = layer_d;
        neuron_nx = neuron_d;
        act_en_nx = 1'b1;
      end
      S_WRITE: begin
        busy_nx   = 1'b1;
        layer_nx  = layer_d;
        neuron_nx = neuron_d;
        wr_en_nx  = 1'b1;
      end
      S_CHECK: begin
        busy_nx   = 1'b1;
        chk_en_nx = 1'b1;
      end
      S_DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: three parameterisations share one clock; a trace
// model built from nested layer/neuron/tap loops is compared every cycle.
module tb_mlp_sequencer;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance (d_), small instance (s_), minimal instance (t_)
  logic       d_rst_n, d_start, d_abort, d_busy, d_done, d_layer;
  logic [7:0] d_neuron_idx, d_tap_idx;
  logic       d_mac_init, d_mac_en, d_act_en, d_wr_en, d_chk_en;
  logic [2:0] d_state;
  logic       s_rst_n, s_start, s_abort, s_busy, s_done, s_layer;
  logic [7:0] s_neuron_idx, s_tap_idx;
  logic       s_mac_init, s_mac_en, s_act_en, s_wr_en, s_chk_en;
  logic [2:0] s_state;
  logic       t_rst_n, t_start, t_abort, t_busy, t_done, t_layer;
  logic [7:0] t_neuron_idx, t_tap_idx;
  logic       t_mac_init, t_mac_en, t_act_en, t_wr_en, t_chk_en;
  logic [2:0] t_state;

  mlp_sequencer u_def (
    .clk(clk), .rst_n(d_rst_n), .start(d_start), .abort(d_abort),
    .busy(d_busy), .done(d_done), .layer(d_layer), .neuron_idx(d_neuron_idx),
    .tap_idx(d_tap_idx), .mac_init(d_mac_init), .mac_en(d_mac_en),
    .act_en(d_act_en), .wr_en(d_wr_en), .chk_en(d_chk_en), .state_dbg(d_state)
  );

  mlp_sequencer #(.N_IN(3), .N_HID(2), .N_OUT(2), .ACT_LAT(2), .CHK_LAT(2)) u_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .layer(s_layer), .neuron_idx(s_neuron_idx),
    .tap_idx(s_tap_idx), .mac_init(s_mac_init), .mac_en(s_mac_en),
    .act_en(s_act_en), .wr_en(s_wr_en), .chk_en(s_chk_en), .state_dbg(s_state)
  );

  mlp_sequencer #(.N_IN(1), .N_HID(1), .N_OUT(1), .ACT_LAT(1), .CHK_LAT(1)) u_tiny (
    .clk(clk), .rst_n(t_rst_n), .start(t_start), .abort(t_abort),
    .busy(t_busy), .done(t_done), .layer(t_layer), .neuron_idx(t_neuron_idx),
    .tap_idx(t_tap_idx), .mac_init(t_mac_init), .mac_en(t_mac_en),
    .act_en(t_act_en), .wr_en(t_wr_en), .chk_en(t_chk_en), .state_dbg(t_state)
  );

  logic [W-1:0] d_vec, s_vec, t_vec;
  assign d_vec = {d_busy, d_done, d_layer, d_neuron_idx, d_tap_idx,
                  d_mac_init, d_mac_en, d_act_en, d_wr_en, d_chk_en};
  assign s_vec = {s_busy, s_done, s_layer, s_neuron_idx, s_tap_idx,
                  s_mac_init, s_mac_en, s_act_en, s_wr_en, s_chk_en};
  assign t_vec = {t_busy, t_done, t_layer, t_neuron_idx, t_tap_idx,
                  t_mac_init, t_mac_en, t_act_en, t_wr_en, t_chk_en};

  logic [W-1:0] exp_q_d[$];
  logic [W-1:0] exp_q_s[$];
  logic [W-1:0] exp_q_t[$];
  logic [W-1:0] trace_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int d_start_cyc, d_done_cyc, d_done_cnt, d_wr0, d_wr1, d_init;
  int s_start_cyc, s_done_cyc, s_done_cnt, s_mac_cnt;
  int t_start_cyc, t_done_cyc, t_done_cnt, t_split;
  int s_tap_log[$];

  function automatic logic [W-1:0] pack(input logic b, input logic d, input logic l,
                                        input int n, input int t, input logic mi,
                                        input logic me, input logic ae, input logic we,
                                        input logic ce);
    logic [7:0] n8, t8;
    n8 = 8'(n);
    t8 = 8'(t);
    return {b, d, l, n8, t8, mi, me, ae, we, ce};
  endfunction

  // Expected output per cycle for one run, from the start-sampling edge to DONE.
  task automatic build_trace(input int ni, input int nh, input int no,
                             input int al, input int cl);
    trace_q.delete();
    for (int ly = 0; ly < 2; ly++) begin
      int nn;
      int fan;
      nn  = (ly == 1) ? no : nh;
      fan = (ly == 1) ? nh : ni;
      for (int n = 0; n < nn; n++) begin
        for (int t = 0; t < fan; t++)
          trace_q.push_back(pack(1'b1, 1'b0, 1'(ly), n, t, (t == 0), 1'b1, 1'b0, 1'b0, 1'b0));
        for (int a = 0; a < al; a++)
          trace_q.push_back(pack(1'b1, 1'b0, 1'(ly), n, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        trace_q.push_back(pack(1'b1, 1'b0, 1'(ly), n, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
    end
    for (int c = 0; c < cl; c++)
      trace_q.push_back(pack(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    trace_q.push_back(pack(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Compare process plus event counters, all sampled on the falling edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      e = (exp_q_d.size() > 0) ? exp_q_d.pop_front() : '0;
      check_vec("def_outputs", d_vec, e);
      e = (exp_q_s.size() > 0) ? exp_q_s.pop_front() : '0;
      check_vec("small_outputs", s_vec, e);
      e = (exp_q_t.size() > 0) ? exp_q_t.pop_front() : '0;
      check_vec("tiny_outputs", t_vec, e);
      if (d_wr_en) begin
        if (d_layer) d_wr1++;
        else d_wr0++;
      end
      if (d_mac_init) d_init++;
      if (d_done) begin d_done_cnt++; d_done_cyc = cyc; end
      if (s_mac_en) begin s_mac_cnt++; s_tap_log.push_back(int'(s_tap_idx)); end
      if (s_done) begin s_done_cnt++; s_done_cyc = cyc; end
      if (t_mac_en != t_mac_init) t_split++;
      if (t_done) begin t_done_cnt++; t_done_cyc = cyc; end
    end
  end

  // One-cycle start pulse; the model trace is queued on the sampling edge.
  task automatic start_run(input int inst);
    @(negedge clk);
    case (inst)
      0: d_start = 1'b1;
      1: s_start = 1'b1;
      default: t_start = 1'b1;
    endcase
    @(posedge clk);
    case (inst)
      0: begin
        build_trace(104, 60, 20, 10, 10);
        exp_q_d = {exp_q_d, trace_q};
        d_start_cyc = cyc; d_done_cnt = 0; d_wr0 = 0; d_wr1 = 0; d_init = 0;
      end
      1: begin
        build_trace(3, 2, 2, 2, 2);
        exp_q_s = {exp_q_s, trace_q};
        s_start_cyc = cyc; s_done_cnt = 0; s_mac_cnt = 0; s_tap_log.delete();
      end
      default: begin
        build_trace(1, 1, 1, 1, 1);
        exp_q_t = {exp_q_t, trace_q};
        t_start_cyc = cyc; t_done_cnt = 0; t_split = 0;
      end
    endcase
    @(negedge clk);
    d_start = 1'b0;
    s_start = 1'b0;
    t_start = 1'b0;
  endtask

  initial begin
    int exp_taps[10];
    int first_start;
    exp_taps = '{0, 1, 2, 0, 1, 2, 0, 1, 0, 1};
    d_rst_n = 1'b0; s_rst_n = 1'b0; t_rst_n = 1'b0;
    d_start = 1'b0; s_start = 1'b0; t_start = 1'b0;
    d_abort = 1'b0; s_abort = 1'b0; t_abort = 1'b0;
    d_done_cnt = 0; s_done_cnt = 0; t_done_cnt = 0;
    d_wr0 = 0; d_wr1 = 0; d_init = 0; s_mac_cnt = 0; t_split = 0;
    d_done_cyc = 0; s_done_cyc = 0; t_done_cyc = 0;
    d_start_cyc = 0; s_start_cyc = 0; t_start_cyc = 0;
    #2;
    check_vec("reset_outputs_def", d_vec, '0);
    check_int("reset_state_dbg", int'(d_state) + int'(s_state) + int'(t_state), 0);
    @(negedge clk);
    @(negedge clk);
    d_rst_n = 1'b1; s_rst_n = 1'b1; t_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Model pins: run lengths for the three parameter sets.
    build_trace(1, 1, 1, 1, 1);
    check_int("model_len_tiny", trace_q.size(), 8);
    build_trace(3, 2, 2, 2, 2);
    check_int("model_len_small", trace_q.size(), 25);
    build_trace(104, 60, 20, 10, 10);
    check_int("model_len_def", trace_q.size(), 8331);
    check_vec("model_pin_abort_point", trace_q[6976],
              pack(1'b1, 1'b0, 1'b1, 1, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Minimal configuration.
    start_run(2);
    repeat (12) @(negedge clk);
    check_int("tiny_done_latency", t_done_cyc - t_start_cyc, 8);
    check_int("tiny_done_count", t_done_cnt, 1);
    check_int("tiny_init_en_split", t_split, 0);

    // Small configuration: latency, tap order, MAC cycle count.
    start_run(1);
    repeat (30) @(negedge clk);
    check_int("small_done_latency", s_done_cyc - s_start_cyc, 25);
    check_int("small_mac_cycles", s_mac_cnt, 10);
    check_int("small_tap_count", s_tap_log.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < s_tap_log.size()) check_int("small_tap_seq", s_tap_log[i], exp_taps[i]);

    // Start held high: one run per IDLE visit, restarting right after DONE.
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    build_trace(3, 2, 2, 2, 2);
    exp_q_s = {exp_q_s, trace_q};
    first_start = cyc; s_done_cnt = 0;
    repeat (26) @(posedge clk);
    exp_q_s = {exp_q_s, trace_q};
    s_start_cyc = cyc;
    @(negedge clk);
    s_start = 1'b0;
    repeat (30) @(negedge clk);
    check_int("held_start_done_count", s_done_cnt, 2);
    check_int("held_start_restart_gap", s_start_cyc - first_start, 26);
    check_int("held_start_second_latency", s_done_cyc - s_start_cyc, 25);

    // Asynchronous reset in the middle of ACT.
    start_run(1);
    repeat (3) @(posedge clk);
    #2;
    check_int("pre_reset_in_act", int'(s_act_en), 1);
    s_rst_n = 1'b0;
    exp_q_s.delete();
    #1;
    check_vec("async_reset_outputs", s_vec, '0);
    @(negedge clk);
    @(posedge clk);
    #2;
    s_rst_n = 1'b1;
    s_done_cnt = 0;
    repeat (10) @(negedge clk);
    check_int("no_resume_after_reset", s_done_cnt, 0);
    start_run(1);
    repeat (30) @(negedge clk);
    check_int("post_reset_run_latency", s_done_cyc - s_start_cyc, 25);

    // Start and abort together in IDLE.
    @(negedge clk);
    d_start = 1'b1; d_abort = 1'b1;
    @(negedge clk);
    d_start = 1'b0; d_abort = 1'b0;
    repeat (3) @(negedge clk);
    check_int("start_abort_stays_idle", int'(d_busy), 0);

    // Full default run.
    start_run(0);
    repeat (8335) @(negedge clk);
    check_int("def_done_latency", d_done_cyc - d_start_cyc, 8331);
    check_int("def_done_count", d_done_cnt, 1);
    check_int("def_wr_hidden", d_wr0, 60);
    check_int("def_wr_output", d_wr1, 20);
    check_int("def_mac_init", d_init, 80);

    // Abort during the second output neuron, then a fresh full run.
    start_run(0);
    repeat (6976) @(posedge clk);
    @(negedge clk);
    d_abort = 1'b1;
    @(posedge clk);
    exp_q_d.delete();
    @(negedge clk);
    d_abort = 1'b0;
    check_int("abort_busy_low", int'(d_busy), 0);
    repeat (20) @(negedge clk);
    check_int("abort_no_done", d_done_cnt, 0);
    start_run(0);
    repeat (8335) @(negedge clk);
    check_int("rerun_done_latency", d_done_cyc - d_start_cyc, 8331);
    check_int("rerun_done_count", d_done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
